// File: rtl/framebuffer_scanout.sv
// Raster-order framebuffer reader: prefetches SRAM words into a small FIFO
// and returns one registered 12-bit RGB pixel per display request.
module framebuffer_scanout #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 400,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iVIDEO_ON,
  input  logic        iFRAME_START,
  input  logic        iPIXEL_REQ,
  output logic [17:0] oMEM_ADDR,
  output logic        oMEM_READ,
  input  logic [15:0] iMEM_DATA,
  output logic [3:0]  oRED,
  output logic [3:0]  oGREEN,
  output logic [3:0]  oBLUE,
  output logic        oPIXEL_VALID,
  output logic        oUNDERFLOW,
  output logic        oFRAME_DONE
);

  localparam int TOTAL = H_RES * V_RES;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [17:0] LAST_ADDR = 18'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FAULT} state_t;

  state_t state_reg, state_next;

  logic [17:0]   addr_cnt_reg;
  logic [17:0]   mem_addr_reg;
  logic          mem_read_reg;
  logic          data_pend_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [11:0]   pix_reg;
  logic          valid_reg, underflow_reg, frame_done_reg;
  logic [11:0]   fifo_mem [FIFO_DEPTH];

  logic          active, pop, underflow, push, issue, last_pop, flush;
  logic [AW+1:0] occupancy;

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (iFRAME_START) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN: begin
          if (underflow)                           state_next = FAULT;
          else if (issue && addr_cnt_reg == LAST_ADDR) state_next = DRAIN;
        end
        DRAIN: begin
          if (underflow)     state_next = FAULT;
          else if (last_pop) state_next = IDLE;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // Control outputs; occupancy counts both reads in flight so the FIFO never overflows
  always_comb begin
    active    = (state_reg == RUN) || (state_reg == DRAIN);
    pop       = 1'b0;
    underflow = 1'b0;
    push      = 1'b0;
    issue     = 1'b0;
    last_pop  = 1'b0;
    occupancy = {1'b0, count_reg} + (AW+2)'(mem_read_reg) + (AW+2)'(data_pend_reg);
    if (!iFRAME_START) begin
      pop       = iPIXEL_REQ && active && (count_reg != '0);
      underflow = iPIXEL_REQ && active && (count_reg == '0);
      push      = data_pend_reg && active && !underflow;
      issue     = (state_reg == RUN) && iVIDEO_ON && !underflow &&
                  (occupancy < (AW+2)'(FIFO_DEPTH));
      last_pop  = (state_reg == DRAIN) && pop && (count_reg == (AW+1)'(1)) &&
                  !mem_read_reg && !data_pend_reg;
    end
    flush = iFRAME_START || underflow;
  end

  always_comb begin
    count_next = count_reg;
    if (flush)              count_next = '0;
    else if (push && !pop)  count_next = count_reg + (AW+1)'(1);
    else if (pop && !push)  count_next = count_reg - (AW+1)'(1);
  end

  // Prefetch storage: no reset so it maps onto RAM
  always_ff @(posedge iCLK) begin
    if (push) fifo_mem[wr_ptr_reg] <= iMEM_DATA[11:0];
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      addr_cnt_reg   <= '0;
      mem_addr_reg   <= '0;
      mem_read_reg   <= 1'b0;
      data_pend_reg  <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      pix_reg        <= '0;
      valid_reg      <= 1'b0;
      underflow_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      mem_read_reg   <= issue;
      // A read already on the bus during a flush returns data that is dropped
      data_pend_reg  <= mem_read_reg && !flush;
      count_reg      <= count_next;
      valid_reg      <= pop;
      pix_reg        <= pop ? fifo_mem[rd_ptr_reg] : 12'h000;
      frame_done_reg <= last_pop;
      if (issue) begin
        mem_addr_reg <= addr_cnt_reg;
        addr_cnt_reg <= addr_cnt_reg + 18'd1;
      end
      if (iFRAME_START) addr_cnt_reg <= '0;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (iFRAME_START)   underflow_reg <= 1'b0;
      else if (underflow) underflow_reg <= 1'b1;
    end
  end

  logic [3:0] chan [3];
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign chan[gi] = pix_reg[4*gi +: 4];
    end
  endgenerate

  assign oBLUE        = chan[0];
  assign oGREEN       = chan[1];
  assign oRED         = chan[2];
  assign oMEM_ADDR    = mem_addr_reg;
  assign oMEM_READ    = mem_read_reg;
  assign oPIXEL_VALID = valid_reg;
  assign oUNDERFLOW   = underflow_reg;
  assign oFRAME_DONE  = frame_done_reg;

endmodule
